// File: rtl/mmi_pkg.sv
// Shared types and default address map for the memory-mapped interconnect controller.
// Slave selects are one-hot in the order [2]=RAM, [1]=CP, [0]=COMM.
package mmi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mmi_state_t;

  localparam logic [2:0] SEL_RAM  = 3'b100;
  localparam logic [2:0] SEL_CP   = 3'b010;
  localparam logic [2:0] SEL_COMM = 3'b001;
  localparam logic [2:0] SEL_NONE = 3'b000;

  localparam logic [31:0] DEF_RAM_LO  = 32'h0000_0000;
  localparam logic [31:0] DEF_RAM_HI  = 32'h0000_0003;
  localparam logic [31:0] DEF_CP_LO   = 32'h0000_0014;
  localparam logic [31:0] DEF_CP_HI   = 32'h0000_0017;
  localparam logic [31:0] DEF_COMM_LO = 32'h0000_0018;
  localparam logic [31:0] DEF_COMM_HI = 32'h0000_001B;

  localparam int unsigned DEF_TIMEOUT = 16;

  // Inclusive range test as one unsigned compare; valid whenever hi >= lo.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr - lo) <= (hi - lo);
  endfunction

endpackage

// File: rtl/mmi_addr_decode.sv
// Combinational byte-address to one-hot slave-select decoder.
// Overlapping regions resolve RAM > CP > COMM; unmapped addresses give SEL_NONE.
module mmi_addr_decode
  import mmi_pkg::*;
#(
  parameter logic [31:0] RAM_LO  = DEF_RAM_LO,
  parameter logic [31:0] RAM_HI  = DEF_RAM_HI,
  parameter logic [31:0] CP_LO   = DEF_CP_LO,
  parameter logic [31:0] CP_HI   = DEF_CP_HI,
  parameter logic [31:0] COMM_LO = DEF_COMM_LO,
  parameter logic [31:0] COMM_HI = DEF_COMM_HI
) (
  input  logic [31:0] i_addr,
  output logic [2:0]  o_sel
);

  always_comb begin
    // NOTE: default assigned first so every path drives o_sel and no latch is inferred.
    o_sel = SEL_NONE;
    if (in_range(i_addr, RAM_LO, RAM_HI)) begin
      o_sel = SEL_RAM;
    end else if (in_range(i_addr, CP_LO, CP_HI)) begin
      o_sel = SEL_CP;
    end else if (in_range(i_addr, COMM_LO, COMM_HI)) begin
      o_sel = SEL_COMM;
    end
  end

endmodule

// File: rtl/mmi_bus_ctrl.sv
// Sequenced single-outstanding bus controller between the core data port and RAM/CP/comm slaves.
// Holds a one-hot select until the selected slave acks or the timeout expires, then pulses one response.
module mmi_bus_ctrl
  import mmi_pkg::*;
#(
  parameter logic [31:0] RAM_LO  = DEF_RAM_LO,
  parameter logic [31:0] RAM_HI  = DEF_RAM_HI,
  parameter logic [31:0] CP_LO   = DEF_CP_LO,
  parameter logic [31:0] CP_HI   = DEF_CP_HI,
  parameter logic [31:0] COMM_LO = DEF_COMM_LO,
  parameter logic [31:0] COMM_HI = DEF_COMM_HI,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [2:0]  o_sel,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_wdata,
  output logic [3:0]  o_s_wstrb,
  input  logic [2:0]  i_s_ack,
  input  logic [31:0] i_s_rdata_ram,
  input  logic [31:0] i_s_rdata_cp,
  input  logic [31:0] i_s_rdata_comm
);

  mmi_state_t  r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [2:0]  r_sel, w_sel_nxt;
  logic        r_ready;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_s_we;
  logic [31:0] r_s_addr, r_s_wdata;
  logic [3:0]  r_s_wstrb;
  logic        w_load_req;
  logic [2:0]  w_dec_sel;
  logic [2:0]  w_ack;
  logic [31:0] w_slave_rdata;

  mmi_addr_decode #(
    .RAM_LO (RAM_LO),  .RAM_HI (RAM_HI),
    .CP_LO  (CP_LO),   .CP_HI  (CP_HI),
    .COMM_LO(COMM_LO), .COMM_HI(COMM_HI)
  ) u_decode (
    .i_addr(i_req_addr),
    .o_sel (w_dec_sel)
  );

  assign w_ack = i_s_ack & r_sel;

  always_comb begin
    unique case (r_sel)
      SEL_RAM: w_slave_rdata = i_s_rdata_ram;
      SEL_CP:  w_slave_rdata = i_s_rdata_cp;
      default: w_slave_rdata = i_s_rdata_comm;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sel_nxt       = r_sel;
    w_load_req      = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_ready && i_req_valid) begin
          w_load_req = 1'b1;
          if (w_dec_sel != SEL_NONE) begin
            w_sel_nxt   = w_dec_sel;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ACCESS;
          end else begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_state_nxt     = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (w_ack != SEL_NONE) begin
          w_sel_nxt       = SEL_NONE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_s_we ? '0 : w_slave_rdata;
          w_state_nxt     = ST_RESP;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_sel_nxt       = SEL_NONE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_state_nxt     = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sel       <= SEL_NONE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_s_we      <= 1'b0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_s_wstrb   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sel       <= w_sel_nxt;
      r_ready     <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      if (w_load_req) begin
        r_s_we    <= i_req_we;
        r_s_addr  <= i_req_addr;
        r_s_wdata <= i_req_wdata;
        r_s_wstrb <= i_req_wstrb;
      end
    end
  end

  assign o_req_ready = r_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_sel       = r_sel;
  assign o_s_we      = r_s_we;
  assign o_s_addr    = r_s_addr;
  assign o_s_wdata   = r_s_wdata;
  assign o_s_wstrb   = r_s_wstrb;

endmodule

// File: tb/tb_mmi_bus_ctrl.sv
// Self-checking bench for mmi_bus_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model of the address map, ack timing and timeout.
module tb_mmi_bus_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_wstrb;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [2:0]  o_sel;
  logic        o_s_we;
  logic [31:0] o_s_addr;
  logic [31:0] o_s_wdata;
  logic [3:0]  o_s_wstrb;
  logic [2:0]  i_s_ack;
  logic [31:0] i_s_rdata_ram;
  logic [31:0] i_s_rdata_cp;
  logic [31:0] i_s_rdata_comm;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mmi_bus_ctrl dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_we      (i_req_we),
    .i_req_addr    (i_req_addr),
    .i_req_wdata   (i_req_wdata),
    .i_req_wstrb   (i_req_wstrb),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_err     (o_rsp_err),
    .o_sel         (o_sel),
    .o_s_we        (o_s_we),
    .o_s_addr      (o_s_addr),
    .o_s_wdata     (o_s_wdata),
    .o_s_wstrb     (o_s_wstrb),
    .i_s_ack       (i_s_ack),
    .i_s_rdata_ram (i_s_rdata_ram),
    .i_s_rdata_cp  (i_s_rdata_cp),
    .i_s_rdata_comm(i_s_rdata_comm)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Address map model: RAM 0x00-0x03, CP 0x14-0x17, COMM 0x18-0x1B, RAM wins overlaps.
  function automatic logic [2:0] model_sel(input logic [31:0] a);
    if (a <= 32'h3)                   return 3'b100;
    if (a >= 32'h14 && a <= 32'h17)   return 3'b010;
    if (a >= 32'h18 && a <= 32'h1B)   return 3'b001;
    return 3'b000;
  endfunction

  // One transaction. ack_delay = ACCESS cycles before the selected slave acks (>= TMO: never).
  // junk = ack bits pulsed on the other slaves, which must be ignored.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int ack_delay, input logic [2:0] junk,
                         input logic [31:0] rd_sel);
    logic [2:0]  exp_sel;
    int          sel_cycles;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          waited;
    exp_sel        = model_sel(addr);
    i_s_rdata_ram  = (exp_sel == 3'b100) ? rd_sel : $urandom;
    i_s_rdata_cp   = (exp_sel == 3'b010) ? rd_sel : $urandom;
    i_s_rdata_comm = (exp_sel == 3'b001) ? rd_sel : $urandom;
    if (exp_sel == 3'b000) begin
      sel_cycles = 0;
      exp_err    = 1'b1;
    end else if (ack_delay >= TMO) begin
      sel_cycles = TMO;
      exp_err    = 1'b1;
    end else begin
      sel_cycles = ack_delay + 1;
      exp_err    = 1'b0;
    end
    exp_rdata = (we || exp_err) ? 32'h0 : rd_sel;

    waited = 0;
    while (!o_req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_req", 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    i_req_wstrb = wstrb;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_req_we    = ~we;
    i_req_addr  = $urandom;
    i_req_wdata = $urandom;
    i_req_wstrb = ~wstrb;
    check("s_we", 32'(o_s_we), 32'(we));
    check("s_wdata", o_s_wdata, wdata);
    check("s_wstrb", 32'(o_s_wstrb), 32'(wstrb));
    check("ready_busy", 32'(o_req_ready), 32'd0);

    for (int k = 0; k < sel_cycles; k++) begin
      check("sel_hold", 32'(o_sel), 32'(exp_sel));
      check("s_addr_hold", o_s_addr, addr);
      check("rsp_quiet", 32'(o_rsp_valid), 32'd0);
      i_s_ack = (k == ack_delay) ? (exp_sel | junk) : (junk & ~exp_sel);
      @(negedge clk);
    end
    i_s_ack = 3'b000;

    check("rsp_valid", 32'(o_rsp_valid), 32'd1);
    check("rsp_err", 32'(o_rsp_err), 32'(exp_err));
    check("rsp_rdata", o_rsp_rdata, exp_rdata);
    check("sel_released", 32'(o_sel), 32'd0);
    @(negedge clk);
    check("rsp_pulse_end", 32'(o_rsp_valid), 32'd0);
    check("rsp_err_clear", 32'(o_rsp_err), 32'd0);
    check("rsp_rdata_clear", o_rsp_rdata, 32'd0);
    check("ready_after", 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    int          t1, t2;
    logic        seen_cp;
    logic [31:0] cp_addr;
    logic [31:0] a;
    int          pick;

    i_rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_we = 1'b0;
    i_req_addr = '0;
    i_req_wdata = '0;
    i_req_wstrb = '0;
    i_s_ack = '0;
    i_s_rdata_ram = '0;
    i_s_rdata_cp = '0;
    i_s_rdata_comm = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(o_req_ready), 32'd0);
    check("reset_sel", 32'(o_sel), 32'd0);
    check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset_s_addr", o_s_addr, 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(o_req_ready), 32'd1);

    // RAM write, immediate ack; RAM read; CP read after 3 wait cycles.
    run_txn(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 0, 3'b000, 32'hAAAA_5555);
    run_txn(1'b0, 32'h0000_0003, 32'h0, 4'h0, 1, 3'b011, 32'hCAFE_F00D);
    run_txn(1'b0, 32'h0000_0014, 32'h0, 4'h0, 3, 3'b000, 32'h1234_5678);
    // Unmapped: hole between RAM and CP, and a high address aliasing CP in the low bits.
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 3'b000, 32'h0);
    run_txn(1'b0, 32'h8000_0014, 32'h0, 4'h0, 0, 3'b111, 32'h0);
    // Comm never acks while RAM ack is pulsed; ack on the very last cycle beats the timeout.
    run_txn(1'b0, 32'h0000_0018, 32'h0, 4'h0, 255, 3'b100, 32'h0BAD_0BAD);
    run_txn(1'b0, 32'h0000_0017, 32'h0, 4'h0, TMO - 1, 3'b101, 32'h5A5A_A5A5);
    run_txn(1'b1, 32'h0000_001B, 32'h0102_0304, 4'h3, TMO, 3'b000, 32'h0);

    // Reset in the middle of an ACCESS.
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 32'h0000_001B;
    @(negedge clk);
    i_req_valid = 1'b0;
    check("rst_mid_sel", 32'(o_sel), 32'b001);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    check("rst_mid_sel_drop", 32'(o_sel), 32'd0);
    check("rst_mid_no_rsp", 32'(o_rsp_valid), 32'd0);
    check("rst_mid_ready", 32'(o_req_ready), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_back", 32'(o_req_ready), 32'd1);
    check("rst_mid_no_rsp2", 32'(o_rsp_valid), 32'd0);

    // Back-to-back with valid held high: RAM then CP, slaves ack as soon as selected.
    t1 = -1;
    t2 = -1;
    seen_cp = 1'b0;
    cp_addr = '0;
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 32'h0000_0000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_sel == 3'b100) i_req_addr = 32'h0000_0014;
      if (o_sel == 3'b010) begin
        seen_cp     = 1'b1;
        cp_addr     = o_s_addr;
        i_req_valid = 1'b0;
      end
      i_s_ack = o_sel;
      if (o_rsp_valid) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) t2 = c;
      end
    end
    i_s_ack = 3'b000;
    i_req_valid = 1'b0;
    check("b2b_first_rsp", 32'(t1), 32'd1);
    check("b2b_gap", 32'(t2 - t1), 32'd3);
    check("b2b_cp_selected", 32'(seen_cp), 32'd1);
    check("b2b_cp_addr", cp_addr, 32'h0000_0014);

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 7)       a = 32'($urandom_range(0, 31));
      else if (pick == 7) a = 32'h8000_0000 | 32'($urandom_range(0, 31));
      else                a = $urandom | 32'h0000_0100;
      run_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, TMO + 2)), 3'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
